// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: two-flop synchroniser plus stability debouncer with edge pulses and rising-edge counter
module sync_debounce_edge #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 3,
  parameter int EDGE_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              D_in,
  output logic              D_out,
  output logic              rise,
  output logic              fall,
  output logic [EDGE_W-1:0] edge_cnt
);
  typedef enum logic [1:0] {STB_LO, CHK_HI, STB_HI, CHK_LO} state_t;
  state_t              state_q, state_d;
  logic                s1_q, s2_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                d_out_q, d_out_d, rise_q, rise_d, fall_q, fall_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic                done;
  assign done = cnt_q == CNT_W'(STABLE_CNT - 1);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_out_d    = d_out_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    edge_cnt_d = edge_cnt_q;
    case (state_q)
      STB_LO: if (s2_q) begin
        state_d = CHK_HI;
        cnt_d   = CNT_W'(1);
      end
      CHK_HI: if (!s2_q) begin
        state_d = STB_LO;
        cnt_d   = '0;
      end else if (done) begin
        state_d    = STB_HI;
        cnt_d      = '0;
        d_out_d    = 1'b1;
        rise_d     = 1'b1;
        edge_cnt_d = edge_cnt_q + EDGE_W'(1);
      end else cnt_d = cnt_q + CNT_W'(1);
      STB_HI: if (!s2_q) begin
        state_d = CHK_LO;
        cnt_d   = CNT_W'(1);
      end
      CHK_LO: if (s2_q) begin
        state_d = STB_HI;
        cnt_d   = '0;
      end else if (done) begin
        state_d = STB_LO;
        cnt_d   = '0;
        d_out_d = 1'b0;
        fall_d  = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = STB_LO;
    endcase
  end
  // reset clears the synchroniser too, so a held input pays the full latency again
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= STB_LO;
      cnt_q      <= '0;
      d_out_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      s1_q       <= D_in;
      s2_q       <= s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_out_q    <= d_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end
  assign D_out    = d_out_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign edge_cnt = edge_cnt_q;
endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge: scoreboard bench with run-length reference model of the debouncer
module tb_sync_debounce_edge;
  localparam int SC = 4;
  localparam int EW = 8;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          D_in = 1'b1;
  logic          D_out, rise, fall;
  logic [EW-1:0] edge_cnt;
  int            errors = 0;
  int            checks = 0;
  logic [EW+2:0] sb[$];
  logic          m_s1 = 1'b0, m_s2 = 1'b0, m_out = 1'b0;
  int            m_run = 0;
  logic [EW-1:0] m_edge = '0;
  int            lat, r, f, rt;

  sync_debounce_edge #(.STABLE_CNT(SC), .CNT_W(3), .EDGE_W(EW)) dut (
    .clk(clk), .reset(reset), .D_in(D_in), .D_out(D_out),
    .rise(rise), .fall(fall), .edge_cnt(edge_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // model: count consecutive synchronised samples that disagree with the output level
  task automatic step(input logic rst_n, input logic d);
    logic mr, mf;
    logic [EW+2:0] exp;
    reset = rst_n;
    D_in  = d;
    mr    = 1'b0;
    mf    = 1'b0;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_out = 0; m_run = 0; m_edge = '0;
    end else begin
      if (m_s2 != m_out) begin
        if (m_run == SC - 1) begin
          m_out = m_s2;
          mr    = m_s2;
          mf    = !m_s2;
          if (m_s2) m_edge = m_edge + 1'b1;
          m_run = 0;
        end else m_run++;
      end else m_run = 0;
      m_s2 = m_s1;
      m_s1 = d;
    end
    sb.push_back({m_out, mr, mf, m_edge});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check("sb", {21'b0, D_out, rise, fall, edge_cnt}, {21'b0, exp});
  endtask

  task automatic hold(input logic d, input int n, output int lat_o, output int rises, output int falls);
    logic start;
    start = D_out;
    lat_o = 0; rises = 0; falls = 0;
    for (int i = 1; i <= n; i++) begin
      step(1'b1, d);
      rises += int'(rise);
      falls += int'(fall);
      if (lat_o == 0 && D_out != start) lat_o = i;
    end
  endtask

  initial begin
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_out", {29'b0, D_out, rise, fall}, 32'd0);
    check("rst_edge", 32'(edge_cnt), 32'd0);
    hold(1'b0, 4, lat, r, f);
    hold(1'b1, 10, lat, r, f);
    check("rise_lat", lat, 6);
    check("rise_cnt", r, 1);
    check("rise_edge", 32'(edge_cnt), 32'd1);
    hold(1'b0, 10, lat, r, f);
    check("fall_lat", lat, 6);
    check("fall_cnt", f, 1);
    check("fall_norise", r, 0);
    check("fall_edge", 32'(edge_cnt), 32'd1);
    hold(1'b1, 3, lat, r, f);
    rt = r;
    hold(1'b0, 8, lat, r, f);
    check("short_rise", rt + r, 0);
    check("short_out", 32'(D_out), 32'd0);
    check("short_edge", 32'(edge_cnt), 32'd1);
    hold(1'b1, 1, lat, r, f); rt = r;
    hold(1'b0, 1, lat, r, f); rt += r;
    hold(1'b1, 1, lat, r, f); rt += r;
    hold(1'b0, 1, lat, r, f); rt += r;
    hold(1'b1, 10, lat, r, f);
    check("bounce_lat", lat, 6);
    check("bounce_rise", rt + r, 1);
    check("bounce_edge", 32'(edge_cnt), 32'd2);
    hold(1'b0, 10, lat, r, f);
    hold(1'b1, 4, lat, r, f);
    step(1'b0, 1'b1);
    check("midrst_out", {29'b0, D_out, rise, fall}, 32'd0);
    check("midrst_edge", 32'(edge_cnt), 32'd0);
    hold(1'b1, 10, lat, r, f);
    check("midrst_lat", lat, 6);
    check("midrst_edge1", 32'(edge_cnt), 32'd1);
    for (int k = 2; k <= 256; k++) begin
      hold(1'b0, 6, lat, r, f);
      hold(1'b1, 6, lat, r, f);
      if (k == 255) check("edge_255", 32'(edge_cnt), 32'd255);
    end
    check("edge_wrap", 32'(edge_cnt), 32'd0);
    check("wrap_out", 32'(D_out), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
